seg7_scan4: RTL and testbench



---
 rtl/seg7_scan4.sv | 125 ++++++++++++
 tb/tb_seg7_scan4.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan4.sv
// Four-digit multiplexed scanner for a common-anode 7-segment display.
// Double-buffered value/dp (pending -> shadow at frame wrap), dead time and leading-zero blanking.
module seg7_scan4 #(
    parameter int CLK_DIV = 100000,
    parameter int DIV_W   = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic        dp,
    output logic [1:0]  digit_idx
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] prescaler;
    logic             tick;
    logic             wrap;
    logic [15:0]      pending_val;
    logic [3:0]       pending_dp;
    logic [15:0]      shadow_val;
    logic [3:0]       shadow_dp;
    logic             dead_q;

    logic [3:0]       sel_nibble;
    logic             sel_dp;
    logic             sel_blanked;
    logic [3:0]       sel_an;
    logic             lit;

    assign tick = (prescaler == DIV_LAST);
    assign wrap = tick && (digit_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            digit_idx <= 2'd0;
        end else if (tick) begin
            prescaler <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            prescaler <= prescaler + DIV_W'(1);
        end
    end

    // A load landing on the wrap tick bypasses pending so it shows in the frame that starts now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_val <= 16'h0000;
            pending_dp  <= 4'b0000;
            shadow_val  <= 16'h0000;
            shadow_dp   <= 4'b0000;
        end else begin
            if (load) begin
                pending_val <= value;
                pending_dp  <= dp_in;
            end
            if (wrap) begin
                shadow_val <= load ? value : pending_val;
                shadow_dp  <= load ? dp_in : pending_dp;
            end
        end
    end

    // Marks the first output cycle of every slot; reset counts as a digit change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dead_q <= 1'b1;
        end else begin
            dead_q <= tick;
        end
    end

    always_comb begin
        sel_nibble  = shadow_val[3:0];
        sel_dp      = shadow_dp[0];
        sel_blanked = 1'b0;
        sel_an      = 4'b1110;
        case (digit_idx)
            2'd0: begin
                sel_nibble  = shadow_val[3:0];
                sel_dp      = shadow_dp[0];
                sel_blanked = 1'b0;
                sel_an      = 4'b1110;
            end
            2'd1: begin
                sel_nibble  = shadow_val[7:4];
                sel_dp      = shadow_dp[1];
                sel_blanked = (shadow_val[15:4] == 12'h000);
                sel_an      = 4'b1101;
            end
            2'd2: begin
                sel_nibble  = shadow_val[11:8];
                sel_dp      = shadow_dp[2];
                sel_blanked = (shadow_val[15:8] == 8'h00);
                sel_an      = 4'b1011;
            end
            default: begin
                sel_nibble  = shadow_val[15:12];
                sel_dp      = shadow_dp[3];
                sel_blanked = (shadow_val[15:12] == 4'h0);
                sel_an      = 4'b0111;
            end
        endcase
        lit = !dead_q && !(blank_lz && sel_blanked);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nibble <= 4'h0;
            an     <= 4'b1111;
            dp     <= 1'b1;
        end else begin
            nibble <= sel_nibble;
            an     <= lit ? sel_an : 4'b1111;
            dp     <= lit ? ~sel_dp : 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan4.sv
// Directed bench for seg7_scan4 with CLK_DIV=4: frame-aligned checks of nibble/an/dp/digit_idx.
module tb_seg7_scan4;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        dp;
    logic [1:0]  digit_idx;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    seg7_scan4 #(.CLK_DIV(4), .DIV_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .value     (value),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .nibble    (nibble),
        .an        (an),
        .dp        (dp),
        .digit_idx (digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns at the negedge just after digit_idx wraps 3 -> 0.
    task automatic sync_frame();
        logic [1:0] prev;
        logic found;
        prev  = digit_idx;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (prev == 2'd3 && digit_idx == 2'd0) found = 1'b1;
            prev = digit_idx;
        end
        check("sync_timeout", {15'd0, found}, 16'd1);
    endtask

    // One 4-cycle slot: dead cycle, then three lit (or blanked) cycles.
    task automatic check_slot(input int d, input logic [3:0] nib, input logic lit, input logic dpbit);
        logic [3:0] one;
        logic [3:0] exp_an;
        logic       exp_dp;
        one    = 4'b0001 << d;
        exp_an = lit ? ~one : 4'b1111;
        exp_dp = lit ? ~dpbit : 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("nib d%0d c%0d", d, c), {12'd0, nibble}, {12'd0, nib});
            if (c == 0) begin
                check($sformatf("an_dead d%0d", d), {12'd0, an}, 16'h000f);
                check($sformatf("dp_dead d%0d", d), {15'd0, dp}, 16'd1);
            end else begin
                check($sformatf("an d%0d c%0d", d, c), {12'd0, an}, {12'd0, exp_an});
                check($sformatf("dp d%0d c%0d", d, c), {15'd0, dp}, {15'd0, exp_dp});
            end
            if (c < 3) check($sformatf("idx d%0d c%0d", d, c), {14'd0, digit_idx}, d[15:0]);
        end
    endtask

    task automatic check_frame(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] lit);
        logic [3:0] nib;
        for (int d = 0; d < 4; d++) exp_q.push_back(v[4*d +: 4]);
        for (int d = 0; d < 4; d++) begin
            nib = exp_q.pop_front();
            check_slot(d, nib, lit[d], dpv[d]);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] dpv);
        value = v;
        dp_in = dpv;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        value = 16'h0;
        dp_in = 4'h0;
    endtask

    // Ends at the negedge just after the wrap edge that captured the load.
    task automatic load_at_wrap(input logic [15:0] v, input logic [3:0] dpv);
        sync_frame();
        repeat (15) @(negedge clk);
        pulse_load(v, dpv);
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h0;
        dp_in    = 4'h0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an", {12'd0, an}, 16'h000f);
        check("rst_nib", {12'd0, nibble}, 16'h0000);
        check("rst_dp", {15'd0, dp}, 16'd1);
        check("rst_idx", {14'd0, digit_idx}, 16'd0);
        rst_n = 1'b1;

        // Idle scan of 0000
        sync_frame();
        check_frame(16'h0000, 4'h0, 4'hf);

        // Load mid-frame at digit1: rest of frame still 0000, next frame 12AF
        repeat (5) @(negedge clk);
        pulse_load(16'h12af, 4'h0);
        repeat (2) @(negedge clk);
        check_slot(2, 4'h0, 1'b1, 1'b0);
        check_slot(3, 4'h0, 1'b1, 1'b0);
        check_frame(16'h12af, 4'h0, 4'hf);

        // Two loads in one frame: last wins
        repeat (2) @(negedge clk);
        pulse_load(16'h1111, 4'h0);
        repeat (3) @(negedge clk);
        pulse_load(16'h2222, 4'h0);
        sync_frame();
        check_frame(16'h2222, 4'h0, 4'hf);

        // Load exactly on the wrap tick shows in the frame starting there
        load_at_wrap(16'h3456, 4'h0);
        check_frame(16'h3456, 4'h0, 4'hf);

        // Leading-zero blanking
        blank_lz = 1'b1;
        load_at_wrap(16'h0030, 4'h0);
        check_frame(16'h0030, 4'h0, 4'b0011);
        blank_lz = 1'b0;
        check_frame(16'h0030, 4'h0, 4'hf);

        // Decimal point on a blanked vs lit digit2
        blank_lz = 1'b1;
        load_at_wrap(16'h0000, 4'b0100);
        check_frame(16'h0000, 4'b0100, 4'b0001);
        blank_lz = 1'b0;
        check_frame(16'h0000, 4'b0100, 4'hf);

        // Reset mid-slot on digit2
        load_at_wrap(16'hbeef, 4'h0);
        repeat (10) @(negedge clk);
        check("pre_rst_an", {12'd0, an}, 16'h000b);
        check("pre_rst_nib", {12'd0, nibble}, 16'h000e);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_an", {12'd0, an}, 16'h000f);
        check("mid_rst_nib", {12'd0, nibble}, 16'h0000);
        check("mid_rst_dp", {15'd0, dp}, 16'd1);
        check("mid_rst_idx", {14'd0, digit_idx}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_frame(16'h0000, 4'h0, 4'hf);
        check_frame(16'h0000, 4'h0, 4'hf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
